// File: rtl/ilm_log_stage_pkg.sv
// Shared widths and the per-operand record for the log-domain multiplier front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: OPW (operand width), FW (fraction width), CW (characteristic
// width), KW (leading-one index width), op_t (per-operand k/f/z record).
package ilm_pkg;

  localparam int OPW = 16;
  localparam int FW  = OPW - 1;
  localparam int CW  = 5;
  localparam int KW  = 4;

  // One operand after leading-one detection: index k, left-aligned fraction f,
  // and a zero flag z (k and f are both 0 when z is set).
  typedef struct packed {
    logic [KW-1:0] k;
    logic [FW-1:0] f;
    logic          z;
  } op_t;

endpackage

// File: rtl/ilm_log_stage_if.sv
// Operand/result handshake bundle for ilm_log_stage.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both sides.
//
// Signals: in_valid/in_ready/in_a/in_b (operand pair in),
// out_valid/out_ready/out_char/out_frac/out_zero (result out).
// slave = stage view, master = producer/consumer view.
interface ilm_log_stage_if;
  import ilm_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_a;
  logic [OPW-1:0] in_b;
  logic           out_valid;
  logic           out_ready;
  logic [CW-1:0]  out_char;
  logic [FW-1:0]  out_frac;
  logic           out_zero;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_char, out_frac, out_zero
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_char, out_frac, out_zero
  );

endinterface

// File: rtl/ilm_log_stage_lod16.sv
// 16-bit leading-one detector and fraction aligner (module lod16).
// Latency: combinational, 0 cycles.
// Backpressure: none (pure function of i_x).
//
// Ports: i_x  - unsigned operand
//        o_op - k = leading-one index, f = bits below the leading one,
//               left-aligned and zero-filled, z = operand is zero
module lod16
  import ilm_pkg::*;
(
  input  logic [OPW-1:0] i_x,
  output op_t            o_op
);

  logic [KW-1:0] w_k;
  logic [KW-1:0] w_sh;

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    w_k = '0;
    for (int i = 0; i < OPW; i++) begin
      if (i_x[i]) begin
        w_k = KW'(i);
      end
    end
  end

  // Shifting by FW-k puts the leading one at bit FW; it is then dropped by the
  // truncation, leaving only the fraction bits. A zero operand gives f=0.
  assign w_sh   = KW'(FW) - w_k;
  assign o_op.k = w_k;
  assign o_op.f = FW'(i_x << w_sh);
  assign o_op.z = (i_x == '0);

endmodule

// File: rtl/ilm_log_stage.sv
// Log-domain multiplier front end: per-operand leading-one split, then log add.
// Latency: 2 cycles in->out when not stalled; one pair per cycle throughput.
// Backpressure: two-slot valid/ready pipeline; in_ready drops only when both slots are full and out_ready=0.
//
// Ports: clk  - rising-edge clock
//        rst  - synchronous active-high reset
//        bus  - ilm_log_stage_if.slave (operand pair in, char/frac/zero out)
// Parameters: OPW operand width (16 only), FW fraction width (OPW-1).
module ilm_log_stage #(
  parameter int OPW = 16,
  parameter int FW  = 15
) (
  input  logic             clk,
  input  logic             rst,
  ilm_log_stage_if.slave   bus
);
  import ilm_pkg::*;

  // S1: leading-one decomposition of both operands.
  op_t w_op_a;
  op_t w_op_b;

  lod16 u_lod_a (
    .i_x  (bus.in_a),
    .o_op (w_op_a)
  );

  lod16 u_lod_b (
    .i_x  (bus.in_b),
    .o_op (w_op_b)
  );

  logic r_s1_vld;
  op_t  r_s1_a;
  op_t  r_s1_b;

  // S2: result register feeding the antilog shifter / decode.
  logic          r_s2_vld;
  logic [CW-1:0] r_s2_char;
  logic [FW-1:0] r_s2_frac;
  logic          r_s2_zero;

  // Stage enables: a stage may load when it is empty or its content leaves.
  logic w_s2_en;
  logic w_s1_en;

  assign w_s2_en      = !r_s2_vld || bus.out_ready;
  assign w_s1_en      = !r_s1_vld || w_s2_en;
  assign bus.in_ready = w_s1_en;

  // Log-domain add of the two S1 records.
  logic [OPW-1:0] w_sum;
  logic           w_carry;
  logic           w_zero;
  logic [CW-1:0]  w_char;
  logic [FW-1:0]  w_frac;

  always_comb begin
    w_sum   = {1'b0, r_s1_a.f} + {1'b0, r_s1_b.f};
    w_carry = w_sum[OPW-1];
    w_zero  = r_s1_a.z | r_s1_b.z;
    // ka,kb <= 15 and carry <= 1, so the sum fits in 5 bits.
    w_char  = CW'(r_s1_a.k) + CW'(r_s1_b.k) + CW'(w_carry);
    // When the fraction sum reaches 1.0, the carry moves into the
    // characteristic and the low bits are the remaining fraction.
    w_frac  = w_sum[FW-1:0];
    // A zero operand still carries the other operand's k/f; clear them.
    if (w_zero) begin
      w_char = '0;
      w_frac = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_a    <= '0;
      r_s1_b    <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_char <= '0;
      r_s2_frac <= '0;
      r_s2_zero <= 1'b0;
    end else begin
      if (w_s1_en) begin
        r_s1_vld <= bus.in_valid;
        if (bus.in_valid) begin
          r_s1_a <= w_op_a;
          r_s1_b <= w_op_b;
        end
      end
      // Data registers hold their value unless new data arrives, so a stalled
      // result stays bit-stable and a drained one is simply marked invalid.
      if (w_s2_en) begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_s2_char <= w_char;
          r_s2_frac <= w_frac;
          r_s2_zero <= w_zero;
        end
      end
    end
  end

  assign bus.out_valid = r_s2_vld;
  assign bus.out_char  = r_s2_char;
  assign bus.out_frac  = r_s2_frac;
  assign bus.out_zero  = r_s2_zero;

endmodule

// File: tb/tb_ilm_log_stage.sv
// Self-checking bench for ilm_log_stage: vector table, stalled stream, reset flush.
module tb_ilm_log_stage;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ilm_log_stage_if bus ();

  ilm_log_stage #(
    .OPW (16),
    .FW  (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  ch;
    logic [14:0] fr;
    logic        z;
  } vec_t;

  typedef struct {
    logic [4:0]  ch;
    logic [14:0] fr;
    logic        z;
  } res_t;

  // Reference: k from repeated halving, fraction from (x - 2^k) scaled to 15 bits.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b);
    res_t r;
    int ia, ib, ka, kb, fa, fb, s, c;
    ia = int'(a);
    ib = int'(b);
    if (ia == 0 || ib == 0) begin
      r.ch = 5'd0;
      r.fr = 15'd0;
      r.z  = 1'b1;
    end else begin
      ka = 0;
      while ((ia >> ka) > 1) ka++;
      kb = 0;
      while ((ib >> kb) > 1) kb++;
      fa = (ia - (1 << ka)) << (15 - ka);
      fb = (ib - (1 << kb)) << (15 - kb);
      s  = fa + fb;
      c  = (s >= 32768) ? 1 : 0;
      r.ch = 5'(ka + kb + c);
      r.fr = 15'(s - c * 32768);
      r.z  = 1'b0;
    end
    return r;
  endfunction

  vec_t vecs[10];
  res_t exp_q[$];
  logic [15:0] sa[8];
  logic [15:0] sb[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h0003, 16'h0005, 5'd3,  15'h6000, 1'b0};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 5'd31, 15'h7FFE, 1'b0};
    vecs[2] = '{16'h0000, 16'h1234, 5'd0,  15'h0000, 1'b1};
    vecs[3] = '{16'h0001, 16'h0001, 5'd0,  15'h0000, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 5'd30, 15'h0000, 1'b0};
    vecs[5] = '{16'h1234, 16'h0000, 5'd0,  15'h0000, 1'b1};
    vecs[6] = '{16'h0002, 16'h0003, 5'd2,  15'h4000, 1'b0};
    vecs[7] = '{16'h00FF, 16'h0100, 5'd15, 15'h7F00, 1'b0};
    vecs[8] = '{16'hC000, 16'hC000, 5'd31, 15'h0000, 1'b0};
    vecs[9] = '{16'h0000, 16'h0000, 5'd0,  15'h0000, 1'b1};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_char",  32'(bus.out_char),  32'd0);
    chk("rst_out_frac",  32'(bus.out_frac),  32'd0);
    chk("rst_out_zero",  32'(bus.out_zero),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Vector table: one pair at a time, 2-cycle latency.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = vecs[i].a;
      bus.in_b     = vecs[i].b;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      chk($sformatf("v%0d_latency1", i), 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("v%0d_char", i), 32'(bus.out_char), 32'(vecs[i].ch));
      chk($sformatf("v%0d_frac", i), 32'(bus.out_frac), 32'(vecs[i].fr));
      chk($sformatf("v%0d_zero", i), 32'(bus.out_zero), 32'(vecs[i].z));
    end

    // Stream of 8 pairs with a 3-cycle output stall in the middle.
    for (int i = 0; i < 8; i++) begin
      sa[i] = 16'($urandom_range(0, 65535));
      sb[i] = 16'($urandom_range(1, 65535));
    end
    sb[5] = 16'h0000;
    begin
      int   sent;
      int   got;
      bit   stalled_prev;
      bit   fell;
      logic [4:0]  p_ch;
      logic [14:0] p_fr;
      logic        p_z;
      res_t r;
      sent = 0;
      got = 0;
      stalled_prev = 1'b0;
      fell = 1'b0;
      p_ch = '0;
      p_fr = '0;
      p_z  = 1'b0;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
        @(negedge clk);
        bus.out_ready = !(cyc >= 4 && cyc < 7);
        bus.in_valid  = (sent < 8);
        bus.in_a      = (sent < 8) ? sa[sent] : 16'h0;
        bus.in_b      = (sent < 8) ? sb[sent] : 16'h0;
        #1;
        if (stalled_prev) begin
          chk("hold_valid", 32'(bus.out_valid), 32'd1);
          chk("hold_char",  32'(bus.out_char),  32'(p_ch));
          chk("hold_frac",  32'(bus.out_frac),  32'(p_fr));
          chk("hold_zero",  32'(bus.out_zero),  32'(p_z));
        end
        if (!bus.in_ready && !fell) begin
          fell = 1'b1;
          chk("pending_at_in_ready_fall", 32'(sent - got), 32'd2);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("stream_unexpected_output", 32'd1, 32'd0);
          end else begin
            r = exp_q.pop_front();
            chk($sformatf("s%0d_char", got), 32'(bus.out_char), 32'(r.ch));
            chk($sformatf("s%0d_frac", got), 32'(bus.out_frac), 32'(r.fr));
            chk($sformatf("s%0d_zero", got), 32'(bus.out_zero), 32'(r.z));
          end
          got++;
        end
        stalled_prev = bus.out_valid && !bus.out_ready;
        p_ch = bus.out_char;
        p_fr = bus.out_frac;
        p_z  = bus.out_zero;
        if (bus.in_valid && bus.in_ready) begin
          exp_q.push_back(model(bus.in_a, bus.in_b));
          sent++;
        end
      end
      chk("stream_results", 32'(got), 32'd8);
      chk("stream_in_ready_fell", 32'(fell), 32'd1);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    // Reset with both stages full: nothing may come out afterwards.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = 16'h0003;
    bus.in_b      = 16'h0005;
    @(negedge clk);
    bus.in_a      = 16'h0007;
    bus.in_b      = 16'h0009;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    #1;
    chk("full_out_valid", 32'(bus.out_valid), 32'd1);
    chk("full_in_ready",  32'(bus.in_ready),  32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_in_ready",  32'(bus.in_ready),  32'd1);
    chk("flush_out_char",  32'(bus.out_char),  32'd0);
    chk("flush_out_frac",  32'(bus.out_frac),  32'd0);
    bus.out_ready = 1'b1;
    begin
      bit stale;
      stale = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        #1;
        if (bus.out_valid) stale = 1'b1;
      end
      chk("flush_no_stale_result", 32'(stale), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
